// File: rtl/fft_seq_ctrl.sv
// Top-level sequencer for the in-place radix-2 FFT: ingest, per-level compute/flush, egress.
// Supports runtime transform size, skip-ingest/egress, inverse flag, flush watchdog and abort.
module fft_seq_ctrl #(
    parameter int unsigned MAX_FFT_SIZE  = 4096,
    parameter int unsigned MIN_FLUSH     = 6,
    parameter int unsigned FLUSH_TIMEOUT = 64,
    parameter int unsigned FRAME_W       = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      fft_go,
    input  logic                                      fft_abort,
    input  logic [$clog2($clog2(MAX_FFT_SIZE)):0]     cfg_log2_size,
    input  logic                                      cfg_inverse,
    input  logic                                      cfg_skip_rx,
    input  logic                                      cfg_skip_tx,
    input  logic                                      axis_bram_slave_busy,
    output logic                                      axis_bram_slave_go,
    input  logic                                      addr_gen_busy,
    output logic                                      addr_gen_go,
    input  logic                                      fft_data_valid,
    input  logic                                      axis_bram_master_busy,
    output logic                                      axis_bram_master_go,
    output logic [$clog2($clog2(MAX_FFT_SIZE))-1:0]   fft_level,
    output logic [$clog2($clog2(MAX_FFT_SIZE)):0]     fft_num_levels,
    output logic                                      fft_inverse,
    output logic                                      rmem_id,
    output logic                                      wmem_id,
    output logic                                      axis_rx,
    output logic                                      axis_tx,
    output logic                                      fft_busy,
    output logic                                      fft_done,
    output logic                                      fft_err,
    output logic                                      cfg_err,
    output logic [FRAME_W-1:0]                        frame_count
);

    localparam int unsigned LEVELS = $clog2(MAX_FFT_SIZE);
    localparam int unsigned LVL_W  = $clog2(LEVELS);
    localparam int unsigned NUM_W  = LVL_W + 1;
    localparam int unsigned CNT_W  = $clog2(FLUSH_TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_MIN_EXIT = CNT_W'(MIN_FLUSH - 1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT  = CNT_W'(FLUSH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AXIS_READ,
        S_COMPUTE,
        S_FLUSH_PIPE,
        S_AXIS_SEND,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 first_q;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [NUM_W-1:0]     num_q, num_d;
    logic                 inv_q, inv_d;
    logic                 skip_rx_q, skip_rx_d;
    logic                 skip_tx_q, skip_tx_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 size_ok;
    logic                 last_level;
    logic                 flush_exit;

    assign size_ok    = (cfg_log2_size != '0) && (cfg_log2_size <= NUM_W'(LEVELS));
    assign last_level = ({1'b0, level_q} >= (num_q - NUM_W'(1)));
    assign flush_exit = !fft_data_valid && (cnt_q >= CNT_MIN_EXIT);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            first_q   <= 1'b0;
            level_q   <= '0;
            num_q     <= '0;
            inv_q     <= 1'b0;
            skip_rx_q <= 1'b0;
            skip_tx_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            first_q   <= (state_d != state_q);
            level_q   <= level_d;
            num_q     <= num_d;
            inv_q     <= inv_d;
            skip_rx_q <= skip_rx_d;
            skip_tx_q <= skip_tx_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
        end
    end

    // Next-state and Mealy go pulses; sub-block busy is ignored on a state's first cycle
    always_comb begin
        state_d             = state_q;
        level_d             = level_q;
        num_d               = num_q;
        inv_d               = inv_q;
        skip_rx_d           = skip_rx_q;
        skip_tx_d           = skip_tx_q;
        err_d               = err_q;
        cnt_d               = cnt_q;
        frame_d             = frame_q;
        axis_bram_slave_go  = 1'b0;
        addr_gen_go         = 1'b0;
        axis_bram_master_go = 1'b0;
        cfg_err             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fft_go && !fft_abort) begin
                    if (!size_ok) begin
                        cfg_err = 1'b1;
                    end else begin
                        num_d     = cfg_log2_size;
                        inv_d     = cfg_inverse;
                        skip_rx_d = cfg_skip_rx;
                        skip_tx_d = cfg_skip_tx;
                        err_d     = 1'b0;
                        level_d   = '0;
                        if (cfg_skip_rx) begin
                            addr_gen_go = 1'b1;
                            state_d     = S_COMPUTE;
                        end else begin
                            axis_bram_slave_go = 1'b1;
                            state_d            = S_AXIS_READ;
                        end
                    end
                end
            end
            S_AXIS_READ: begin
                if (!first_q && !axis_bram_slave_busy) begin
                    addr_gen_go = 1'b1;
                    state_d     = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (!first_q && !addr_gen_busy) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH_PIPE;
                end
            end
            S_FLUSH_PIPE: begin
                cnt_d = (cnt_q == CNT_TIMEOUT) ? cnt_q : cnt_q + CNT_W'(1);
                if (flush_exit) begin
                    if (!last_level) begin
                        level_d     = level_q + LVL_W'(1);
                        addr_gen_go = 1'b1;
                        state_d     = S_COMPUTE;
                    end else if (skip_tx_q) begin
                        state_d = S_DONE;
                    end else begin
                        axis_bram_master_go = 1'b1;
                        state_d             = S_AXIS_SEND;
                    end
                end else if (cnt_q == CNT_TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_AXIS_SEND: begin
                if (!first_q && !axis_bram_master_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                frame_d = frame_q + FRAME_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every transition outside IDLE
        if (fft_abort && (state_q != S_IDLE)) begin
            state_d             = S_IDLE;
            level_d             = '0;
            frame_d             = frame_q;
            err_d               = err_q;
            axis_bram_slave_go  = 1'b0;
            addr_gen_go         = 1'b0;
            axis_bram_master_go = 1'b0;
        end

        if (reset) begin
            axis_bram_slave_go  = 1'b0;
            addr_gen_go         = 1'b0;
            axis_bram_master_go = 1'b0;
            cfg_err             = 1'b0;
        end
    end

    assign fft_level      = level_q;
    assign fft_num_levels = num_q;
    assign fft_inverse    = inv_q;
    assign rmem_id        = level_q[0];
    assign wmem_id        = ~level_q[0];
    assign axis_rx        = (state_q == S_AXIS_READ);
    assign axis_tx        = (state_q == S_AXIS_SEND);
    assign fft_busy       = (state_q != S_IDLE);
    assign fft_done       = (state_q == S_DONE);
    assign fft_err        = err_q;
    assign frame_count    = frame_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: expected go/done/cfg_err events are queued at stimulus
// time and popped as the DUT emits them, with follow-up checks one cycle later.
module tb_fft_seq_ctrl;

    localparam int unsigned MAX_FFT_SIZE  = 4096;
    localparam int unsigned MIN_FLUSH     = 6;
    localparam int unsigned FLUSH_TIMEOUT = 64;
    localparam int unsigned FRAME_W       = 16;
    localparam int          ADDR_LEN      = 4;
    localparam int          RX_LEN        = 5;
    localparam int          TX_LEN        = 3;

    localparam int EV_SLAVE  = 1;
    localparam int EV_ADDR   = 2;
    localparam int EV_MASTER = 3;
    localparam int EV_DONE   = 4;
    localparam int EV_CFGERR = 5;

    typedef struct {
        int kind;
        int a;
        int b;
        int gap;
    } ev_t;

    logic               clk;
    logic               reset;
    logic               fft_go;
    logic               fft_abort;
    logic [4:0]         cfg_log2_size;
    logic               cfg_inverse;
    logic               cfg_skip_rx;
    logic               cfg_skip_tx;
    logic               axis_bram_slave_busy;
    logic               axis_bram_slave_go;
    logic               addr_gen_busy;
    logic               addr_gen_go;
    logic               fft_data_valid;
    logic               axis_bram_master_busy;
    logic               axis_bram_master_go;
    logic [3:0]         fft_level;
    logic [4:0]         fft_num_levels;
    logic               fft_inverse;
    logic               rmem_id;
    logic               wmem_id;
    logic               axis_rx;
    logic               axis_tx;
    logic               fft_busy;
    logic               fft_done;
    logic               fft_err;
    logic               cfg_err;
    logic [FRAME_W-1:0] frame_count;

    fft_seq_ctrl #(
        .MAX_FFT_SIZE (MAX_FFT_SIZE),
        .MIN_FLUSH    (MIN_FLUSH),
        .FLUSH_TIMEOUT(FLUSH_TIMEOUT),
        .FRAME_W      (FRAME_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .fft_go               (fft_go),
        .fft_abort            (fft_abort),
        .cfg_log2_size        (cfg_log2_size),
        .cfg_inverse          (cfg_inverse),
        .cfg_skip_rx          (cfg_skip_rx),
        .cfg_skip_tx          (cfg_skip_tx),
        .axis_bram_slave_busy (axis_bram_slave_busy),
        .axis_bram_slave_go   (axis_bram_slave_go),
        .addr_gen_busy        (addr_gen_busy),
        .addr_gen_go          (addr_gen_go),
        .fft_data_valid       (fft_data_valid),
        .axis_bram_master_busy(axis_bram_master_busy),
        .axis_bram_master_go  (axis_bram_master_go),
        .fft_level            (fft_level),
        .fft_num_levels       (fft_num_levels),
        .fft_inverse          (fft_inverse),
        .rmem_id              (rmem_id),
        .wmem_id              (wmem_id),
        .axis_rx              (axis_rx),
        .axis_tx              (axis_tx),
        .fft_busy             (fft_busy),
        .fft_done             (fft_done),
        .fft_err              (fft_err),
        .cfg_err              (cfg_err),
        .frame_count          (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_err = 0;
    ev_t sb[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    task automatic push(input int kind, input int a, input int b, input int gap);
        ev_t e;
        e.kind = kind;
        e.a    = a;
        e.b    = b;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    // Sub-block models: busy rises the cycle after go; valid trails addr_gen busy by tail_len
    int rx_cnt, ag_cnt, tail_cnt, tx_cnt;
    int tail_len;
    bit hold_en;
    int hold_lvl;

    always @(posedge clk) begin
        if (reset) begin
            rx_cnt   <= 0;
            ag_cnt   <= 0;
            tail_cnt <= 0;
            tx_cnt   <= 0;
        end else begin
            rx_cnt <= axis_bram_slave_go ? RX_LEN : (rx_cnt > 0 ? rx_cnt - 1 : 0);
            tx_cnt <= axis_bram_master_go ? TX_LEN : (tx_cnt > 0 ? tx_cnt - 1 : 0);
            ag_cnt <= addr_gen_go ? ADDR_LEN : (ag_cnt > 0 ? ag_cnt - 1 : 0);
            if (ag_cnt == 1 && !addr_gen_go) tail_cnt <= tail_len;
            else if (tail_cnt > 0)           tail_cnt <= tail_cnt - 1;
        end
    end

    assign axis_bram_slave_busy  = (rx_cnt > 0);
    assign axis_bram_master_busy = (tx_cnt > 0);
    assign addr_gen_busy         = (ag_cnt > 0);
    assign fft_data_valid        = (ag_cnt > 0) || (tail_cnt > 0) ||
                                   (hold_en && fft_busy && int'(fft_level) == hold_lvl);

    // Output monitor: pops the scoreboard on each event, follow-up checks one cycle later
    int  cyc, last_cyc, n_evt, k, rxtx_cyc;
    bit  pend;
    ev_t pe, e;

    always @(negedge clk) begin
        if (reset) begin
            pend     = 1'b0;
            cyc      = 0;
            last_cyc = 0;
        end else begin
            cyc++;
            if (axis_rx || axis_tx) rxtx_cyc++;
            if (pend) begin
                pend = 1'b0;
                case (pe.kind)
                    EV_SLAVE:  check("rx_state", int'(axis_rx), 1);
                    EV_ADDR: begin
                        check("level", int'(fft_level), pe.a);
                        check("rmem_id", int'(rmem_id), pe.a % 2);
                        check("wmem_id", int'(wmem_id), 1 - pe.a % 2);
                    end
                    EV_MASTER: check("tx_state", int'(axis_tx), 1);
                    EV_DONE: begin
                        check("frame_count", int'(frame_count), pe.a);
                        check("fft_err", int'(fft_err), pe.b);
                        check("idle_after_done", int'(fft_busy), 0);
                    end
                    EV_CFGERR: check("busy_after_cfg_err", int'(fft_busy), 0);
                    default: ;
                endcase
            end
            n_evt = int'(axis_bram_slave_go) + int'(addr_gen_go) + int'(axis_bram_master_go)
                  + int'(fft_done) + int'(cfg_err);
            if (n_evt > 0) begin
                if (n_evt > 1)              k = 99;
                else if (axis_bram_slave_go) k = EV_SLAVE;
                else if (addr_gen_go)        k = EV_ADDR;
                else if (axis_bram_master_go) k = EV_MASTER;
                else if (fft_done)           k = EV_DONE;
                else                         k = EV_CFGERR;
                if (sb.size() == 0) begin
                    check("unexpected_event", k, 0);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", k, e.kind);
                    if (e.gap >= 0) check("event_gap", cyc - last_cyc, e.gap);
                    pe   = e;
                    pend = 1'b1;
                end
                last_cyc = cyc;
            end
        end
    end

    task automatic expect_frame(input int size, input int rx, input int tx, input int tail,
                                input int fc);
        if (rx == 0) push(EV_SLAVE, 0, 0, -1);
        for (int l = 0; l < size; l++)
            push(EV_ADDR, l, 0, (l == 0) ? -1 : ADDR_LEN + 2 + imax(MIN_FLUSH - 1, tail - 1));
        if (tx == 0) push(EV_MASTER, 0, 0, -1);
        push(EV_DONE, fc, 0, -1);
    endtask

    task automatic start(input int size, input int rx, input int tx, input int inv);
        @(posedge clk); #1;
        cfg_log2_size = 5'(size);
        cfg_skip_rx   = rx[0];
        cfg_skip_tx   = tx[0];
        cfg_inverse   = inv[0];
        fft_go        = 1'b1;
        @(negedge clk);
        if (rx != 0) check("addr_go_with_go", int'(addr_gen_go), 1);
        else         check("slave_go_with_go", int'(axis_bram_slave_go), 1);
        @(posedge clk); #1;
        fft_go = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (!fft_busy) break;
            @(posedge clk); #1;
        end
        check("frame_end_timeout", int'(fft_busy), 0);
        @(negedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic bad_go(input int size, input string tag);
        push(EV_CFGERR, 0, 0, -1);
        @(posedge clk); #1;
        cfg_log2_size = 5'(size);
        cfg_skip_rx   = 1'b1;
        fft_go        = 1'b1;
        @(negedge clk);
        check(tag, int'(cfg_err), 1);
        @(posedge clk); #1;
        fft_go = 1'b0;
        check("busy_after_bad_go", int'(fft_busy), 0);
        @(negedge clk);
        @(negedge clk);
        check("sb_drained_bad_go", sb.size(), 0);
    endtask

    initial begin
        reset         = 1'b1;
        fft_go        = 1'b1;
        fft_abort     = 1'b0;
        cfg_log2_size = 5'd4;
        cfg_inverse   = 1'b0;
        cfg_skip_rx   = 1'b1;
        cfg_skip_tx   = 1'b0;
        tail_len      = 6;
        hold_en       = 1'b0;
        hold_lvl      = 0;
        rxtx_cyc      = 0;

        // Reset: go held high must produce no pulses
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_addr_go", int'(addr_gen_go), 0);
        check("rst_slave_go", int'(axis_bram_slave_go), 0);
        @(posedge clk); #1;
        fft_go = 1'b0;
        reset  = 1'b0;
        check("rst_busy", int'(fft_busy), 0);
        check("rst_level", int'(fft_level), 0);
        check("rst_frame", int'(frame_count), 0);
        check("rst_err", int'(fft_err), 0);
        check("rst_num_levels", int'(fft_num_levels), 0);
        check("rst_done", int'(fft_done), 0);

        // Full-size frame with ingest and egress
        tail_len = 6;
        expect_frame(12, 0, 0, 6, 1);
        start(12, 0, 0, 1);
        wait_idle();
        check("inverse_latched", int'(fft_inverse), 1);
        check("num_levels_12", int'(fft_num_levels), 12);

        // Chained frame: skip ingest and egress
        rxtx_cyc = 0;
        expect_frame(3, 1, 1, 6, 2);
        start(3, 1, 1, 0);
        wait_idle();
        check("no_rx_tx_cycles", rxtx_cyc, 0);
        check("final_level", int'(fft_level), 2);

        // Illegal sizes
        bad_go(0, "cfg_err_size0");
        bad_go(13, "cfg_err_size13");

        // Flush watchdog at level 4
        hold_en  = 1'b1;
        hold_lvl = 4;
        for (int l = 0; l <= 4; l++)
            push(EV_ADDR, l, 0, (l == 0) ? -1 : ADDR_LEN + 2 + MIN_FLUSH - 1);
        push(EV_DONE, 3, 1, ADDR_LEN + 2 + int'(FLUSH_TIMEOUT));
        start(8, 1, 0, 0);
        wait_idle();
        hold_en = 1'b0;
        check("err_sticky", int'(fft_err), 1);

        // Abort mid-COMPUTE at level 5; the go also clears the sticky error
        for (int l = 0; l <= 5; l++)
            push(EV_ADDR, l, 0, (l == 0) ? -1 : ADDR_LEN + 2 + MIN_FLUSH - 1);
        start(10, 1, 1, 0);
        check("err_cleared_by_go", int'(fft_err), 0);
        for (int i = 0; i < 500; i++) begin
            if (int'(fft_level) == 5) break;
            @(posedge clk); #1;
        end
        check("reached_level5", int'(fft_level), 5);
        fft_abort = 1'b1;
        @(negedge clk);
        check("abort_no_go", int'(addr_gen_go), 0);
        @(posedge clk); #1;
        fft_abort = 1'b0;
        check("abort_idle", int'(fft_busy), 0);
        check("abort_level", int'(fft_level), 0);
        check("abort_frame", int'(frame_count), 3);
        check("abort_no_done", int'(fft_done), 0);
        @(negedge clk);
        check("sb_drained_abort", sb.size(), 0);

        // Abort together with go in IDLE rejects the go
        @(posedge clk); #1;
        cfg_log2_size = 5'd4;
        cfg_skip_rx   = 1'b1;
        fft_go        = 1'b1;
        fft_abort     = 1'b1;
        @(negedge clk);
        check("abort_go_no_addr_go", int'(addr_gen_go), 0);
        check("abort_go_no_cfg_err", int'(cfg_err), 0);
        @(posedge clk); #1;
        fft_go    = 1'b0;
        fft_abort = 1'b0;
        check("abort_go_idle", int'(fft_busy), 0);
        repeat (15) @(posedge clk);

        // Early valid drop still waits MIN_FLUSH cycles; go while busy is ignored
        tail_len = 2;
        expect_frame(4, 0, 0, 2, 4);
        start(4, 0, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        cfg_log2_size = 5'd2;
        cfg_skip_rx   = 1'b1;
        cfg_inverse   = 1'b1;
        fft_go        = 1'b1;
        @(posedge clk); #1;
        fft_go = 1'b0;
        wait_idle();
        check("num_levels_kept", int'(fft_num_levels), 4);
        check("inverse_kept", int'(fft_inverse), 0);
        check("frame_final", int'(frame_count), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
